// File: rtl/max7219_spi_tx.sv
// MAX7219 serial transmitter: shifts one 16-bit register write (addr, data) MSB-first
// onto Din/CLK framed by an active-low CS, reporting progress through busy/done.
module max7219_spi_tx #(
  parameter int unsigned SYS_FREQ_KHZ  = 50000,
  parameter int unsigned SCLK_FREQ_KHZ = 12
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       str,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       CS,
  output logic       CLK,
  output logic       Din
);

  // Half serial-clock period in sys_clk cycles; never below one cycle.
  localparam int unsigned HalfRaw = SYS_FREQ_KHZ / (2 * SCLK_FREQ_KHZ);
  localparam int unsigned Half    = (HalfRaw == 0) ? 1 : HalfRaw;
  localparam int unsigned PhaseW  = $clog2(Half + 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(Half - 1);

  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StGap} state_e;

  state_e            state_q, state_d;
  logic [15:0]       shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  // last_q: bit 0 has been clocked, so the next LOW phase is the trailing hold.
  logic              last_q, last_d;
  // gap_q: first half of the 2*Half gap has elapsed (keeps the phase counter narrow).
  logic              gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              clk_q, clk_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              phase_end;

  assign phase_end = (phase_q == PhaseLast);

  // State and registered pin drivers.
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      last_q    <= 1'b0;
      gap_q     <= 1'b0;
      cs_q      <= 1'b1;
      clk_q     <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      cs_q      <= cs_d;
      clk_q     <= clk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: phase counter paces every state, transitions happen on phase_end.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_end ? '0 : phase_q + 1'b1;
    last_d    = last_q;
    gap_d     = gap_q;
    cs_d      = cs_q;
    clk_d     = clk_q;
    din_d     = din_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (str) begin
          shift_d   = {addr, data};
          din_d     = addr[7];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd15;
          last_d    = 1'b0;
          gap_d     = 1'b0;
          state_d   = StLead;
        end
      end
      StLead: begin
        if (phase_end) begin
          state_d = StHigh;
          clk_d   = 1'b1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          state_d = StLow;
          clk_d   = 1'b0;
          // Din moves on the falling edge so it is stable around each rise.
          if (bit_cnt_q != 4'd0) begin
            shift_d   = {shift_q[14:0], 1'b0};
            din_d     = shift_q[14];
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else begin
            last_d = 1'b1;
          end
        end
      end
      StLow: begin
        if (phase_end) begin
          if (last_q) begin
            state_d = StGap;
            cs_d    = 1'b1;
            din_d   = 1'b0;
            gap_d   = 1'b0;
          end else begin
            state_d = StHigh;
            clk_d   = 1'b1;
          end
        end
      end
      StGap: begin
        if (phase_end) begin
          if (gap_q) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = 1'b0;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign CS   = cs_q;
  assign CLK  = clk_q;
  assign Din  = din_q;

endmodule

// File: tb/tb_max7219_spi_tx.sv
// Directed bench for max7219_spi_tx: Half=2 instance for most scenarios, Half=1 instance
// for the minimum-divider case. Outputs are sampled on the falling sys_clk edge.
module tb_max7219_spi_tx;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       str, str1;
  logic [7:0] addr, data, addr1, data1;
  logic       busy, done, cs, sclk, din;
  logic       busy1, done1, cs1, sclk1, din1;

  int checks = 0;
  int errors = 0;

  // Monitor state for the Half=2 instance.
  int          cyc;
  int          n_rise;
  int          rise_cyc[16];
  logic [15:0] word;
  int          cs_low_cyc, busy_cyc, done_cnt, din_hi_toggle;
  int          n_xfer, n_fall, busy_fall_first;
  logic [15:0] xfer_words[4];
  int          cs_fall_cyc[4];
  logic        prev_clk, prev_din, prev_cs, prev_busy;

  max7219_spi_tx #(.SYS_FREQ_KHZ(48), .SCLK_FREQ_KHZ(12)) dut (
    .sys_clk(sys_clk), ._rst(rst_n), .str(str), .addr(addr), .data(data),
    .busy(busy), .done(done), .CS(cs), .CLK(sclk), .Din(din)
  );

  max7219_spi_tx #(.SYS_FREQ_KHZ(10), .SCLK_FREQ_KHZ(12)) dut1 (
    .sys_clk(sys_clk), ._rst(rst_n), .str(str1), .addr(addr1), .data(data1),
    .busy(busy1), .done(done1), .CS(cs1), .CLK(sclk1), .Din(din1)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic clear_stats();
    cyc = 0; n_rise = 0; word = '0;
    cs_low_cyc = 0; busy_cyc = 0; done_cnt = 0; din_hi_toggle = 0;
    n_xfer = 0; n_fall = 0; busy_fall_first = -1;
    for (int i = 0; i < 16; i++) rise_cyc[i] = -1;
    for (int i = 0; i < 4; i++) begin xfer_words[i] = '0; cs_fall_cyc[i] = -1; end
    prev_clk = 1'b0; prev_din = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0;
  endtask

  // Called once per falling sys_clk edge; cyc = sys_clk edges since acceptance.
  task automatic sample();
    if (sclk && !prev_clk) begin
      if (n_rise < 16) rise_cyc[n_rise] = cyc;
      n_rise++;
      word = {word[14:0], din};
    end
    if (sclk && prev_clk && din !== prev_din) din_hi_toggle++;
    if (!cs && prev_cs) begin
      if (n_fall < 4) cs_fall_cyc[n_fall] = cyc;
      n_fall++;
    end
    if (cs && !prev_cs) begin
      if (n_xfer < 4) xfer_words[n_xfer] = word;
      n_xfer++;
    end
    if (!busy && prev_busy && busy_fall_first < 0) busy_fall_first = cyc;
    if (!cs) cs_low_cyc++;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    prev_clk = sclk; prev_din = din; prev_cs = cs; prev_busy = busy;
    cyc++;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    clear_stats();
    str = 1'b1; addr = a; data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; str = 1'b0; addr = '0; data = '0;
    str1 = 1'b0; addr1 = '0; data1 = '0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({busy, done, cs, sclk, din} !== 5'b00100) begin
      errors++; $display("FAIL reset_outputs: got %b exp 00100", {busy, done, cs, sclk, din});
    end
    checks++;
    if ({busy1, done1, cs1, sclk1, din1} !== 5'b00100) begin
      errors++; $display("FAIL reset_outputs1: got %b exp 00100",
                         {busy1, done1, cs1, sclk1, din1});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({busy, done, cs, sclk, din} !== 5'b00100) begin
      errors++; $display("FAIL idle_outputs: got %b exp 00100", {busy, done, cs, sclk, din});
    end
  endtask

  task automatic test_basic();
    start(8'h0C, 8'h01);
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (i == 0) str = 1'b0;
      sample();
    end
    checks++;
    if (cs_low_cyc != 66) begin errors++; $display("FAIL basic_cs_low: got %0d exp 66", cs_low_cyc); end
    checks++;
    if (busy_cyc != 70) begin errors++; $display("FAIL basic_busy: got %0d exp 70", busy_cyc); end
    checks++;
    if (n_rise != 16) begin errors++; $display("FAIL basic_rises: got %0d exp 16", n_rise); end
    checks++;
    if (rise_cyc[0] != 2 || rise_cyc[1] != 6 || rise_cyc[15] != 62) begin
      errors++; $display("FAIL basic_rise_times: got %0d %0d %0d exp 2 6 62",
                         rise_cyc[0], rise_cyc[1], rise_cyc[15]);
    end
    checks++;
    if (word !== 16'h0C01) begin errors++; $display("FAIL basic_word: got %h exp 0c01", word); end
    checks++;
    if (done_cnt != 1 || busy_fall_first != 70) begin
      errors++; $display("FAIL basic_done: got %0d pulses busy_fall %0d exp 1 70",
                         done_cnt, busy_fall_first);
    end
  endtask

  task automatic test_pattern();
    start(8'hA5, 8'h5A);
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (i == 0) begin
        str = 1'b0;
        checks++;
        if (din !== 1'b1 || cs !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL accept_outputs: got din=%b cs=%b busy=%b exp 1 0 1",
                             din, cs, busy);
        end
      end
      sample();
    end
    checks++;
    if (word !== 16'hA55A) begin errors++; $display("FAIL pattern_word: got %h exp a55a", word); end
    checks++;
    if (din_hi_toggle != 0) begin
      errors++; $display("FAIL din_stable_high: got %0d toggles exp 0", din_hi_toggle);
    end
  endtask

  task automatic test_back_to_back();
    start(8'h11, 8'h22);
    for (int i = 0; i < 260; i++) begin
      @(negedge sys_clk);
      sample();
      if (i == 30) begin addr = 8'h33; data = 8'h44; end
      if (i == 100) begin addr = 8'h55; data = 8'h66; end
      if (i == 199) str = 1'b0;
    end
    checks++;
    if (n_xfer != 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", n_xfer); end
    checks++;
    if (xfer_words[0] !== 16'h1122 || xfer_words[1] !== 16'h3344 || xfer_words[2] !== 16'h5566) begin
      errors++; $display("FAIL b2b_words: got %h %h %h exp 1122 3344 5566",
                         xfer_words[0], xfer_words[1], xfer_words[2]);
    end
    checks++;
    if (busy_fall_first != 70 || cs_fall_cyc[1] != 71 || cs_fall_cyc[2] != 142) begin
      errors++; $display("FAIL b2b_gap: got busy_fall %0d cs_fall %0d %0d exp 70 71 142",
                         busy_fall_first, cs_fall_cyc[1], cs_fall_cyc[2]);
    end
    checks++;
    if (done_cnt != 3) begin errors++; $display("FAIL b2b_done: got %0d exp 3", done_cnt); end
  endtask

  task automatic test_str_while_busy();
    start(8'h12, 8'h34);
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (i == 0) str = 1'b0;
      if (i == 20) begin str = 1'b1; addr = 8'hEE; data = 8'hEE; end
      if (i == 21) str = 1'b0;
      sample();
    end
    checks++;
    if (n_xfer != 1 || xfer_words[0] !== 16'h1234) begin
      errors++; $display("FAIL ignore_str_xfer: got %0d xfers word %h exp 1 1234",
                         n_xfer, xfer_words[0]);
    end
    checks++;
    if (done_cnt != 1 || busy_cyc != 70) begin
      errors++; $display("FAIL ignore_str_done: got %0d pulses busy %0d exp 1 70",
                         done_cnt, busy_cyc);
    end
  endtask

  task automatic test_async_reset();
    start(8'hFF, 8'h00);
    for (int i = 0; i < 200 && n_rise < 7; i++) begin
      @(negedge sys_clk);
      if (i == 0) str = 1'b0;
      sample();
    end
    checks++;
    if (n_rise != 7) begin errors++; $display("FAIL reset_wait: got %0d rises exp 7", n_rise); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cs, sclk, din} !== 4'b0100) begin
      errors++; $display("FAIL async_reset: got %b exp 0100", {busy, cs, sclk, din});
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    start(8'h96, 8'h3C);
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (i == 0) str = 1'b0;
      sample();
    end
    checks++;
    if (word !== 16'h963C || n_rise != 16 || done_cnt != 1) begin
      errors++; $display("FAIL post_reset_xfer: got word %h rises %0d done %0d exp 963c 16 1",
                         word, n_rise, done_cnt);
    end
  endtask

  task automatic test_min_half();
    int          b_cnt, r_cnt, r_first, r_last;
    logic [15:0] w;
    logic        pc;
    b_cnt = 0; r_cnt = 0; r_first = -1; r_last = -1; w = '0; pc = 1'b0;
    @(negedge sys_clk);
    str1 = 1'b1; addr1 = 8'hC3; data1 = 8'h7E;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (i == 0) str1 = 1'b0;
      if (busy1) b_cnt++;
      if (sclk1 && !pc) begin
        if (r_first < 0) r_first = i;
        r_last = i;
        r_cnt++;
        w = {w[14:0], din1};
      end
      pc = sclk1;
    end
    checks++;
    if (b_cnt != 35) begin errors++; $display("FAIL half1_busy: got %0d exp 35", b_cnt); end
    checks++;
    if (r_cnt != 16 || r_first != 1 || r_last != 31) begin
      errors++; $display("FAIL half1_rises: got %0d first %0d last %0d exp 16 1 31",
                         r_cnt, r_first, r_last);
    end
    checks++;
    if (w !== 16'hC37E) begin errors++; $display("FAIL half1_word: got %h exp c37e", w); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_pattern();
    test_back_to_back();
    test_str_while_busy();
    test_async_reset();
    test_min_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_spi_tx.md
# max7219_spi_tx

Serial transmitter for the MAX7219 8x8 LED driver: accepts one 16-bit register write (8-bit address, 8-bit data), shifts it MSB-first onto Din/CLK framed by CS, and reports completion through busy. It sits directly downstream of the display sequencer, which presents a register address/data pair, pulses str and advances on the falling edge of busy. The block is the only driver of the MAX7219 pins.

## Interface
- SYS_FREQ_KHZ, 50000: sys_clk frequency in kHz.
- SCLK_FREQ_KHZ, 12: target serial clock (CLK) frequency in kHz.
- Derived HALF = SYS_FREQ_KHZ / (2*SCLK_FREQ_KHZ), integer division, forced to 1 if result is 0; phase counter width = $clog2(HALF+1).

- sys_clk  in  1  system clock; all logic on posedge.
- _rst  in  1  reset; **one clock; reset is asynchronous and active-low**.
- str  in  1  start request, active high, sampled on sys_clk.
- addr  in  8  MAX7219 register address (word bits 15:8).
- data  in  8  register data (word bits 7:0).
- busy  out  1  high from transfer acceptance until transfer fully complete.
- done  out  1  one-cycle pulse coincident with busy falling.
- CS  out  1  MAX7219 LOAD/CS, active low.
- CLK  out  1  serial clock, idles low.
- Din  out  1  serial data.

## Operation
- Reset values: busy=0, done=0, CS=1, CLK=0, Din=0, state IDLE, shift register 0, bit counter 0, phase counter 0.
- States: IDLE, LEAD, HIGH, LOW, GAP. Each of LEAD/HIGH/LOW lasts exactly HALF sys_clk cycles; GAP lasts 2*HALF.
- IDLE: on an edge with str=1: shift <= {addr,data}, Din <= addr[7], CS <= 0, busy <= 1, bit counter <= 15, go LEAD. str=0: stay.
- LEAD: CS low, CLK low, Din = bit 15 (setup). End -> HIGH, CLK <= 1.
- HIGH: CLK high (MAX7219 samples on rising edge). End -> LOW, CLK <= 0; if bit counter > 0, Din <= next lower bit, decrement counter.
- LOW: CLK low. If bits remain, end -> HIGH, CLK <= 1. After bit 0's LOW phase (trailing hold), end -> GAP, CS <= 1 (MAX7219 latches word on CS rise), Din <= 0.
- GAP: CS high, CLK low. End -> IDLE, busy <= 0, done <= 1 for one cycle.
- Exactly 16 CLK rising edges per transfer; word order addr[7]..addr[0], data[7]..data[0].
- addr/data sampled only at acceptance; changes while busy ignored. str while busy ignored (no queuing).
- str held high continuously: a new transfer is accepted on the first edge in IDLE, i.e. the cycle after busy falls.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately; CS rising may latch a partial word in the MAX7219 — upstream re-initialises all registers after every reset.

## Timing
- Acceptance latency: str sampled at edge k -> CS low, busy high, Din=addr[7] after edge k.
- First CLK rise after edge k+HALF; rise n (1..16) after edge k+HALF+2*HALF*(n-1).
- Din changes only on CLK falling edges (same sys_clk edge); stable HALF cycles before and after each rise.
- CS rises after edge k+33*HALF; busy falls and done pulses after edge k+35*HALF. busy high 35*HALF cycles.
- With defaults HALF=2083: CLK ≈ 12.0 kHz, transfer ≈ 1.46 ms.

## Test plan
- Parameters SYS_FREQ_KHZ=48, SCLK_FREQ_KHZ=12 (HALF=2), str pulse addr=0x0C data=0x01 -> CS low 66 cycles, 16 CLK rises each 4 cycles apart, captured word 0x0C01, busy high exactly 70 cycles, single done pulse.
- Word 0xA5 / 0x5A -> bench shift model on CLK rise reads 0xA55A; Din never toggles while CLK high.
- str held high for 200 cycles, addr/data changed mid-transfer -> back-to-back transfers, 1 idle cycle between busy fall and next CS fall; each word equals addr/data at its acceptance edge.
- str pulse during busy -> ignored; exactly one transfer, done pulses once.
- _rst asserted low after 7th CLK rise -> CS=1, CLK=0, Din=0, busy=0 immediately (asynchronously); after release, new str yields a full correct 16-bit transfer.
- SYS_FREQ_KHZ=10, SCLK_FREQ_KHZ=12 (HALF forced 1) -> CLK period 2 cycles, busy high 35 cycles, word correct.
